// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard bus: instruction descriptor from the decoder and stall flags back to the pipeline.
// master drives the ID descriptor; slave is the scoreboard.
interface hazard_scoreboard_if #(
   parameter int NUM_READ = 2,
   parameter int TW       = 2
);
   logic                     id_valid;
   logic [5*NUM_READ-1:0]    id_ra;
   logic [TW*NUM_READ-1:0]   id_tuse;
   logic [4:0]               id_wa;
   logic                     id_we;
   logic [TW-1:0]            id_tnew;
   logic                     id_md_start;
   logic                     id_md_div;
   logic                     id_md_use;
   logic                     stall;
   logic                     stall_data;
   logic                     stall_md;
   logic                     md_busy;

   modport master (
      output id_valid, id_ra, id_tuse, id_wa, id_we, id_tnew,
             id_md_start, id_md_div, id_md_use,
      input  stall, stall_data, stall_md, md_busy
   );

   modport slave (
      input  id_valid, id_ra, id_tuse, id_wa, id_we, id_tnew,
             id_md_start, id_md_div, id_md_use,
      output stall, stall_data, stall_md, md_busy
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Stall generator keeping a shadow E/M/W pipeline of register writers and a mult/div busy counter.
// Optional feature macro: HAZARD_MD_STALL_EN builds the md counter and md stall.
module hazard_scoreboard #(
   parameter int NUM_READ    = 2,
   parameter int DEPTH       = 3,
   parameter int TW          = 2,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic                   clk,
   input  logic                   reset_n,
   hazard_scoreboard_if.slave     sb_if
);

   logic [4:0]    wa_q   [DEPTH];
   logic          we_q   [DEPTH];
   logic [TW-1:0] tnew_q [DEPTH];
   logic [4:0]    wa_d   [DEPTH];
   logic          we_d   [DEPTH];
   logic [TW-1:0] tnew_d [DEPTH];

   logic [NUM_READ-1:0] hz_vec;
   logic                stall_data;
   logic                stall_md;
   logic                md_busy;
   logic                stall;

   assign stall = stall_data | stall_md;

   // Stage 0 takes the ID instruction, or a bubble when ID is stalled or empty.
   always_comb begin
      wa_d[0]   = '0;
      we_d[0]   = 1'b0;
      tnew_d[0] = '0;
      if (sb_if.id_valid && !stall) begin
         wa_d[0]   = sb_if.id_wa;
         we_d[0]   = sb_if.id_we && (sb_if.id_wa != 5'd0);
         tnew_d[0] = sb_if.id_tnew;
      end
   end

   for (genvar gi = 1; gi < DEPTH; gi++) begin : g_age
      always_comb begin
         wa_d[gi]   = wa_q[gi-1];
         we_d[gi]   = we_q[gi-1];
         tnew_d[gi] = (tnew_q[gi-1] == '0) ? '0 : tnew_q[gi-1] - TW'(1);
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            wa_q[gi]   <= '0;
            we_q[gi]   <= 1'b0;
            tnew_q[gi] <= '0;
         end else begin
            wa_q[gi]   <= wa_d[gi];
            we_q[gi]   <= we_d[gi];
            tnew_q[gi] <= tnew_d[gi];
         end
      end
   end

   // Scanning from the oldest stage down lets the youngest match overwrite older ones.
   for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_operand
      logic [4:0]    ra;
      logic [TW-1:0] tuse;
      logic          hit;
      logic [TW-1:0] hit_tnew;

      assign ra   = sb_if.id_ra[5*gi +: 5];
      assign tuse = sb_if.id_tuse[TW*gi +: TW];

      always_comb begin
         hit      = 1'b0;
         hit_tnew = '0;
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (we_q[k] && (wa_q[k] == ra)) begin
               hit      = 1'b1;
               hit_tnew = tnew_q[k];
            end
         end
      end

      assign hz_vec[gi] = sb_if.id_valid && (ra != 5'd0) && hit && (hit_tnew > tuse);
   end

   assign stall_data = |hz_vec;

`ifdef HAZARD_MD_STALL_EN
   localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int MD_W   = $clog2(MD_MAX + 1);

   logic [MD_W-1:0] md_cnt_q;
   logic [MD_W-1:0] md_cnt_d;

   always_comb begin
      md_cnt_d = md_cnt_q;
      if (sb_if.id_valid && sb_if.id_md_start && !stall) begin
         md_cnt_d = sb_if.id_md_div ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
      end else if (md_cnt_q != '0) begin
         md_cnt_d = md_cnt_q - MD_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         md_cnt_q <= '0;
      end else begin
         md_cnt_q <= md_cnt_d;
      end
   end

   assign md_busy  = (md_cnt_q != '0);
   assign stall_md = sb_if.id_valid && sb_if.id_md_use && md_busy;
`else
   logic unused_md;
   assign unused_md = ^{sb_if.id_md_start, sb_if.id_md_div, sb_if.id_md_use,
                        MULT_CYCLES[0], DIV_CYCLES[0]};
   assign md_busy   = 1'b0;
   assign stall_md  = 1'b0;
`endif

   assign sb_if.stall      = stall;
   assign sb_if.stall_data = stall_data;
   assign sb_if.stall_md   = stall_md;
   assign sb_if.md_busy    = md_busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios plus randomized traffic
// compared against an age-based reference model of in-flight writers and the md unit.
module tb_hazard_scoreboard;

   localparam int NR    = 2;
   localparam int DEPTH = 3;
   localparam int TW    = 2;
   localparam int MULTC = 5;
   localparam int DIVC  = 10;
`ifdef HAZARD_MD_STALL_EN
   localparam bit MD_EN = 1'b1;
`else
   localparam bit MD_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   hazard_scoreboard_if #(.NUM_READ(NR), .TW(TW)) bus ();

   hazard_scoreboard #(
      .NUM_READ(NR), .DEPTH(DEPTH), .TW(TW), .MULT_CYCLES(MULTC), .DIV_CYCLES(DIVC)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .sb_if   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: each stage remembers the writer's tnew at issue; its live tnew is that minus its age.
   logic [4:0] m_wa [DEPTH];
   logic       m_we [DEPTH];
   int         m_tn [DEPTH];
   int         cyc;
   int         md_end;

   function automatic bit exp_stall_data();
      for (int p = 0; p < NR; p++) begin
         logic [4:0] ra;
         int         tuse;
         ra   = bus.id_ra[5*p +: 5];
         tuse = int'(bus.id_tuse[TW*p +: TW]);
         if (bus.id_valid && ra != 5'd0) begin
            for (int k = 0; k < DEPTH; k++) begin
               if (m_we[k] && m_wa[k] == ra) begin
                  int live;
                  live = m_tn[k] - k;
                  if (live < 0) live = 0;
                  if (live > tuse) return 1'b1;
                  break;
               end
            end
         end
      end
      return 1'b0;
   endfunction

   function automatic bit exp_md_busy();
      return MD_EN && (cyc < md_end);
   endfunction

   function automatic bit exp_stall_md();
      return bus.id_valid && bus.id_md_use && exp_md_busy();
   endfunction

   function automatic bit exp_stall();
      return exp_stall_data() || exp_stall_md();
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            m_wa[k] <= '0;
            m_we[k] <= 1'b0;
            m_tn[k] <= 0;
         end
         cyc    <= 0;
         md_end <= 0;
      end else begin
         bit accept;
         accept = bus.id_valid && !exp_stall();
         cyc     <= cyc + 1;
         m_wa[0] <= bus.id_wa;
         m_we[0] <= accept && bus.id_we && (bus.id_wa != 5'd0);
         m_tn[0] <= int'(bus.id_tnew);
         for (int k = 1; k < DEPTH; k++) begin
            m_wa[k] <= m_wa[k-1];
            m_we[k] <= m_we[k-1];
            m_tn[k] <= m_tn[k-1];
         end
         if (MD_EN && accept && bus.id_md_start)
            md_end <= cyc + 1 + (bus.id_md_div ? DIVC : MULTC);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input int ra0, input int tu0, input int ra1, input int tu1,
                        input int wa, input bit we, input int tn,
                        input bit st, input bit dv, input bit us);
      bus.id_valid    = v;
      bus.id_ra       = {5'(ra1), 5'(ra0)};
      bus.id_tuse     = {TW'(tu1), TW'(tu0)};
      bus.id_wa       = 5'(wa);
      bus.id_we       = we;
      bus.id_tnew     = TW'(tn);
      bus.id_md_start = st;
      bus.id_md_div   = dv;
      bus.id_md_use   = us;
      #1;
      $display("[TB] t=%0t v=%0b ra=%0d/%0d tuse=%0d/%0d wa=%0d we=%0b tnew=%0d md=%0b%0b%0b -> stall=%0b sd=%0b sm=%0b busy=%0b",
               $time, v, ra0, ra1, tu0, tu1, wa, we, tn, st, dv, us,
               bus.stall, bus.stall_data, bus.stall_md, bus.md_busy);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         tick();
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive(1, 8, 0, 9, 0, 8, 1, 3, 1, 1, 1);
      n_tests += 4;
      if (bus.stall !== 1'b0)      begin n_fail++; $display("FAIL reset_stall: got %0b want 0", bus.stall); end
      if (bus.stall_data !== 1'b0) begin n_fail++; $display("FAIL reset_stall_data: got %0b want 0", bus.stall_data); end
      if (bus.stall_md !== 1'b0)   begin n_fail++; $display("FAIL reset_stall_md: got %0b want 0", bus.stall_md); end
      if (bus.md_busy !== 1'b0)    begin n_fail++; $display("FAIL reset_md_busy: got %0b want 0", bus.md_busy); end
      tick();
      tick();
      reset_n = 1'b1;
      idle(1);
   endtask

   task automatic test_load_use();
      drive(1, 0, 0, 0, 0, 8, 1, 2, 0, 0, 0);          // lw $8
      n_tests++;
      if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL lu_issue: stall=%0b want 0", bus.stall); end
      tick();
      drive(1, 8, 1, 0, 0, 9, 1, 1, 0, 0, 0);          // add reading $8, tuse=1
      n_tests += 2;
      if (bus.stall !== 1'b1)      begin n_fail++; $display("FAIL lu_stall: stall=%0b want 1", bus.stall); end
      if (bus.stall_data !== 1'b1) begin n_fail++; $display("FAIL lu_stall_data: got %0b want 1", bus.stall_data); end
      tick();
      drive(1, 8, 1, 0, 0, 9, 1, 1, 0, 0, 0);
      n_tests++;
      if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL lu_release: stall=%0b want 0", bus.stall); end
      tick();
      idle(4);
   endtask

   task automatic test_store_data();
      drive(1, 0, 0, 0, 0, 8, 1, 2, 0, 0, 0);          // lw $8
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 29, 1, 8, 2, 0, 0, 0, 0, 0, 0);      // sw with $8 as store data, tuse=2
         n_tests++;
         if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL sw_data_%0d: stall=%0b want 0", i, bus.stall); end
         tick();
      end
      idle(4);
   endtask

   task automatic test_zero_and_youngest();
      drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);          // addu $0
      tick();
      drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);          // reader of $0, tuse=0
      n_tests++;
      if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL zero_reg: stall=%0b want 0", bus.stall); end
      tick();
      idle(4);
      drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);          // addu $5
      tick();
      drive(1, 0, 0, 0, 0, 5, 1, 2, 0, 0, 0);          // lw $5
      tick();
      drive(1, 0, 0, 5, 1, 6, 1, 1, 0, 0, 0);          // reader of $5 on operand 1, tuse=1
      n_tests++;
      if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL youngest: stall=%0b want 1", bus.stall); end
      tick();
      idle(4);
   endtask

   task automatic test_md_busy();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);          // div
      n_tests++;
      if (bus.md_busy !== 1'b0) begin n_fail++; $display("FAIL md_pre: busy=%0b want 0", bus.md_busy); end
      tick();
      for (int i = 1; i <= DIVC + 1; i++) begin
         bit want;
         want = MD_EN && (i <= DIVC);
         drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 1);       // mflo held in ID
         n_tests += 3;
         if (bus.md_busy !== want)  begin n_fail++; $display("FAIL md_busy_c%0d: got %0b want %0b", i, bus.md_busy, want); end
         if (bus.stall_md !== want) begin n_fail++; $display("FAIL md_stall_c%0d: got %0b want %0b", i, bus.stall_md, want); end
         if (bus.stall !== want)    begin n_fail++; $display("FAIL md_stall_all_c%0d: got %0b want %0b", i, bus.stall, want); end
         tick();
      end
      idle(4);
   endtask

   task automatic test_async_reset();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);          // div
      tick();
      drive(1, 0, 0, 0, 0, 8, 1, 2, 0, 0, 0);          // lw $8
      tick();
      drive(1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 1);          // md user reading $8, tuse=0
      n_tests += 2;
      if (bus.stall_data !== 1'b1) begin n_fail++; $display("FAIL ar_pre_data: got %0b want 1", bus.stall_data); end
      if (bus.stall_md !== MD_EN)  begin n_fail++; $display("FAIL ar_pre_md: got %0b want %0b", bus.stall_md, MD_EN); end
      reset_n = 1'b0;
      #1;
      n_tests += 4;
      if (bus.stall !== 1'b0)      begin n_fail++; $display("FAIL ar_stall: got %0b want 0", bus.stall); end
      if (bus.stall_data !== 1'b0) begin n_fail++; $display("FAIL ar_stall_data: got %0b want 0", bus.stall_data); end
      if (bus.stall_md !== 1'b0)   begin n_fail++; $display("FAIL ar_stall_md: got %0b want 0", bus.stall_md); end
      if (bus.md_busy !== 1'b0)    begin n_fail++; $display("FAIL ar_md_busy: got %0b want 0", bus.md_busy); end
      tick();
      reset_n = 1'b1;
      drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 1);          // mflo right after release
      n_tests++;
      if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL ar_mflo: stall=%0b want 0", bus.stall); end
      tick();
      idle(4);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         bit us, st;
         us = ($urandom_range(0, 7) == 0);
         st = us && $urandom_range(0, 1);
         drive($urandom_range(0, 3) != 0,
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
               st, $urandom_range(0, 1), us);
         n_tests += 4;
         if (bus.stall_data !== exp_stall_data()) begin n_fail++; $display("FAIL rnd_data_%0d: got %0b want %0b", i, bus.stall_data, exp_stall_data()); end
         if (bus.stall_md !== exp_stall_md())     begin n_fail++; $display("FAIL rnd_md_%0d: got %0b want %0b", i, bus.stall_md, exp_stall_md()); end
         if (bus.md_busy !== exp_md_busy())       begin n_fail++; $display("FAIL rnd_busy_%0d: got %0b want %0b", i, bus.md_busy, exp_md_busy()); end
         if (bus.stall !== exp_stall())           begin n_fail++; $display("FAIL rnd_stall_%0d: got %0b want %0b", i, bus.stall, exp_stall()); end
         tick();
      end
      idle(4);
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_store_data();
      test_zero_and_youngest();
      test_md_busy();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
